// File: rtl/wordboard_pkg.sv
// Shared definitions for the wordboard controller: FSM state encoding,
// word/frame widths and default timing constants.
package wordboard_pkg;

  localparam int unsigned WORD_W           = 4;
  localparam int unsigned FRAME_W          = 5;
  localparam int unsigned DEF_DEBOUNCE_CYC = 500000;
  localparam int unsigned DEF_BIT_CYC      = 12500000;
  localparam int unsigned DEF_GAP_CYC      = 25000000;
  localparam int unsigned DEF_DEPTH        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Serial frame: start bit followed by the word, MSB first.
  function automatic frame_t make_frame(input word_t w);
    return {1'b1, w};
  endfunction

endpackage

// File: rtl/wordboard_if.sv
// Board-side signal bundle of the wordboard controller.
//   sw1..sw4   : word switches (sw4 = MSB), asynchronous
//   btn_write  : raw write button, asynchronous
//   btn_auto   : raw playback button, asynchronous
//   out        : serial output
//   busy       : playback in progress
//   full       : memory full
//   count      : number of stored words
// master = board/stimulus side, slave = controller side.
interface wordboard_if
  import wordboard_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             sw1;
  logic             sw2;
  logic             sw3;
  logic             sw4;
  logic             btn_write;
  logic             btn_auto;
  logic             out;
  logic             busy;
  logic             full;
  logic [CNT_W-1:0] count;

  modport master (
    output sw1, sw2, sw3, sw4, btn_write, btn_auto,
    input  out, busy, full, count
  );

  modport slave (
    input  sw1, sw2, sw3, sw4, btn_write, btn_auto,
    output out, busy, full, count
  );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level counter and
// rising-edge pulse of the debounced level.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_btn        : raw bouncing button level
//   o_pulse      : one-cycle pulse when the debounced level rises
module btn_debounce
  import wordboard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             w_expire;

  // Synced level has differed from the accepted level long enough.
  assign w_expire = (r_sync[1] != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= w_expire && r_sync[1];
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/wordboard_ctrl.sv
// Wordboard controller: debounces the buttons, stores switch words in a
// small memory and plays them back serially on out.
//   sysclk, rst : clock, asynchronous active-high reset
//   io_bus      : switches/buttons in; out, busy, full, count out
module wordboard_ctrl
  import wordboard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned BIT_CYC      = DEF_BIT_CYC,
  parameter int unsigned GAP_CYC      = DEF_GAP_CYC,
  parameter int unsigned DEPTH        = DEF_DEPTH
) (
  input logic        sysclk,
  input logic        rst,
  wordboard_if.slave io_bus
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned CYC_MAX = (BIT_CYC > GAP_CYC) ? BIT_CYC : GAP_CYC;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  logic w_wr_pulse;
  logic w_auto_pulse;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_write (
    .i_clk  (sysclk),
    .i_rst  (rst),
    .i_btn  (io_bus.btn_write),
    .o_pulse(w_wr_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_auto (
    .i_clk  (sysclk),
    .i_rst  (rst),
    .i_btn  (io_bus.btn_auto),
    .o_pulse(w_auto_pulse)
  );

  state_t           r_state, w_state_nxt;
  word_t            r_sw_meta, r_sw_sync;
  word_t            r_mem [DEPTH];
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
  logic [BIT_W-1:0] r_bit, w_bit_nxt;
  frame_t           r_shift, w_shift_nxt;
  logic             r_out, w_out_nxt;
  logic             r_busy, r_full;
  logic             w_mem_we;

  // Register stage: state, datapath and registered outputs.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_cyc     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sw_meta <= {io_bus.sw4, io_bus.sw3, io_bus.sw2, io_bus.sw1};
      r_sw_sync <= r_sw_meta;
      r_count   <= w_count_nxt;
      r_idx     <= w_idx_nxt;
      r_cyc     <= w_cyc_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_out     <= w_out_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_full    <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  // Word memory; contents are only reachable below count, so no reset.
  always_ff @(posedge sysclk) begin
    if (w_mem_we) begin
      r_mem[r_count[IDX_W-1:0]] <= r_sw_sync;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_out_nxt   = 1'b0;
    w_mem_we    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_wr_pulse && w_auto_pulse) begin
          w_count_nxt = '0;
        end else if (w_wr_pulse) begin
          if (r_count < CNT_W'(DEPTH)) begin
            w_mem_we    = 1'b1;
            w_count_nxt = r_count + CNT_W'(1);
          end
        end else if (w_auto_pulse && (r_count != '0)) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_shift_nxt = make_frame(r_mem[r_idx]);
        w_bit_nxt   = '0;
        w_cyc_nxt   = '0;
        w_out_nxt   = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_cyc == CYC_W'(BIT_CYC - 1)) begin
          w_cyc_nxt = '0;
          if (r_bit == BIT_W'(FRAME_W - 1)) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
            w_out_nxt   = r_shift[FRAME_W-2];
          end
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
          w_out_nxt = r_shift[FRAME_W-1];
        end
      end
      ST_GAP: begin
        if (r_cyc == CYC_W'(GAP_CYC - 1)) begin
          w_cyc_nxt = '0;
          if ((CNT_W'(r_idx) + CNT_W'(1)) < r_count) begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Auto press during playback aborts; write presses here are dropped.
    if ((r_state != ST_IDLE) && w_auto_pulse) begin
      w_state_nxt = ST_IDLE;
      w_cyc_nxt   = '0;
      w_out_nxt   = 1'b0;
    end
  end

  assign io_bus.out   = r_out;
  assign io_bus.busy  = r_busy;
  assign io_bus.full  = r_full;
  assign io_bus.count = r_count;

endmodule

// File: doc/wordboard_ctrl.md
# wordboard_ctrl

Controller and scheduler for the wordboard output. It debounces the two push buttons, captures 4-bit words from the switches into a small word memory on each write press, and plays the stored words back serially on `out` when auto is pressed. It sits between the board I/O (switches, buttons) and the single serial output pin, and owns all sequencing of that pin.

## Interface
- `DEBOUNCE_CYC`, 500000: consecutive stable cycles before a button level is accepted (10 ms at 50 MHz).
- `BIT_CYC`, 12500000: cycles per serial bit slot (250 ms).
- `GAP_CYC`, 25000000: idle-low cycles after each word.
- `DEPTH`, 8: word memory entries, power of two, 2..16.
- `sysclk  in  1  system clock, 50 MHz`
- `rst  in  1  reset, asynchronous, active-high`
- `sw1..sw4  in  1 each  word bits, sw4 = MSB, sw1 = LSB; asynchronous inputs`
- `btn_write  in  1  raw write button, bouncing, asynchronous`
- `btn_auto  in  1  raw auto/playback button, bouncing, asynchronous`
- `out  out  1  serial output, registered`
- `busy  out  1  high while in any playback state`
- `full  out  1  high when count == DEPTH`
- `count  out  $clog2(DEPTH)+1  number of stored words`

## Operation
- All asynchronous inputs pass through 2-FF synchronizers.
- Debounce per button: debounced level changes only after the synced level differs from it for `DEBOUNCE_CYC` consecutive cycles; any return resets the counter. Rising edge of debounced level -> one-cycle press pulse.
- Word = {sw4,sw3,sw2,sw1}, sampled (synced) in the cycle of the write pulse.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE: `out`=0.
  - write pulse alone, count<DEPTH: mem[count] <= word, count++. At DEPTH: ignored, contents unchanged.
  - auto pulse alone, count>0: idx<=0 -> LOAD. count==0: ignored.
  - write and auto pulse in the same cycle: clear, count<=0; no playback.
- LOAD: `out`=0, fetch mem[idx] into shift register with leading start bit (5 bits: 1, d3, d2, d1, d0) -> SHIFT.
- SHIFT: each bit held `BIT_CYC` cycles, MSB-first after start bit; after 5th bit -> GAP.
- GAP: `out`=0 for `GAP_CYC` cycles; then idx++ -> LOAD if idx+1 < count, else IDLE.
- Auto pulse in LOAD/SHIFT/GAP: abort -> IDLE, `out`=0 from the next cycle. Write pulses outside IDLE are dropped (not queued).
- Memory and count survive playback and abort; cleared only by clear or reset.

## Timing
- Reset (async assert, sync release): state IDLE, `out`=0, `busy`=0, `full`=0, `count`=0, debounced levels 0, all counters 0. Memory contents undefined but unreachable.
- Button press to pulse: 2 sync cycles + `DEBOUNCE_CYC` + 1.
- Auto pulse in cycle n: LOAD in n+1, `out`=1 from n+2. `busy` high from n+1 through last GAP cycle.
- Word period exactly 1 + 5·`BIT_CYC` + `GAP_CYC` cycles; no extra cycles between words.
- `count`/`full` update the cycle after the write pulse.
- Reset mid-playback: `out` low asynchronously, stays IDLE.

## Structure
- Shared package `wordboard_pkg`: state encoding, `WORD_W`=4, `FRAME_W`=5, default cycle constants.
- Sub-module `btn_debounce` (synchronizer + stable counter + edge pulse), instantiated twice. Serializer, memory and FSM stay in `wordboard_ctrl`.

## Test plan
Parameters for bench: `DEBOUNCE_CYC`=4, `BIT_CYC`=2, `GAP_CYC`=3, `DEPTH`=4.
- Reset asserted mid-cycle -> `out`=0, `busy`=0, `count`=0, `full`=0 immediately.
- btn_write glitch high 3 cycles, sw=4'b1001 -> `count` stays 0; held 10 cycles -> `count`=1 exactly once.
- Five write presses with distinct words -> `count`=4, `full`=1, 5th ignored; playback shows first four words only.
- Stored 1001, 0110, auto press -> `out` per word: 0 (LOAD), 11 11 00 00 11 / 11 00 11 11 00, 000; `busy` falls after 2nd gap.
- Auto press during 2nd bit of word 0 -> `out`=0 next cycle, IDLE; next auto restarts at word 0.
- Simultaneous write+auto pulse with `count`=3 -> `count`=0, no output; auto press then ignored; reset during SHIFT -> `out`=0 at once.
